// File: rtl/ibex_instr_responder.sv
// Instruction-fetch responder: grants Ibex fetches, reads a word-wide SRAM, returns data with fixed 2-cycle latency.
// Optional macro IBEX_INSTR_RESP_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module ibex_instr_responder #(
  parameter int unsigned NUM_REQS  = 2,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned CW        = $clog2(NUM_REQS + 1);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic [32:0]   w_offset;
  logic          w_in_range;
  logic          w_slot_free;
  logic          w_stall_ok;
  logic          w_gnt;
  logic [CW-1:0] w_outst_next;

  logic [CW-1:0] r_outst;
  logic          r_s1_valid;
  logic          r_s1_err;
  logic          r_s2_valid;
  logic          r_s2_err;
  logic [31:0]   r_s2_rdata;

  // Addresses below the base wrap to a huge 33-bit offset, so one compare covers both bounds.
  assign w_offset   = {1'b0, instr_addr_i} - {1'b0, MEM_BASE};
  assign w_in_range = (w_offset < MEM_BYTES);

  // A response leaving this cycle frees its slot for a new grant in the same cycle.
  assign w_slot_free = ((r_outst - CW'(instr_rvalid_o)) < CW'(NUM_REQS));

`ifdef IBEX_INSTR_RESP_STALL_EN
  logic [6:0] r_lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= 7'h5A;
    end else begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  assign w_stall_ok = r_lfsr[0];
`else
  assign w_stall_ok = 1'b1;
`endif

  assign w_gnt        = instr_req_i & w_slot_free & w_stall_ok & ~rst_i;
  assign instr_gnt_o  = w_gnt;
  assign mem_req_o    = w_gnt & w_in_range;
  assign mem_addr_o   = mem_req_o ? w_offset[AW+1:2] : '0;
  assign w_outst_next = r_outst + CW'(w_gnt) - CW'(instr_rvalid_o);

  // S1 tracks grant validity/error; S2 captures the SRAM word one cycle after the strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_rdata <= '0;
    end else begin
      r_outst    <= w_outst_next;
      r_s1_valid <= w_gnt;
      r_s1_err   <= w_gnt & ~w_in_range;
      r_s2_valid <= r_s1_valid;
      r_s2_err   <= r_s1_valid & r_s1_err;
      r_s2_rdata <= (r_s1_valid & ~r_s1_err) ? mem_rdata_i : '0;
    end
  end

  // Reset masks the response stage immediately so an in-flight word never escapes during reset.
  assign instr_rvalid_o = r_s2_valid & ~rst_i;
  assign instr_err_o    = r_s2_err & ~rst_i;
  assign instr_rdata_o  = rst_i ? 32'h0 : r_s2_rdata;

endmodule

// File: tb/tb_ibex_instr_responder.sv
// Scoreboard bench for ibex_instr_responder: default instance for data/ordering/reset, NUM_REQS=1 instance for grant limiting.
module tb_ibex_instr_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt, rvalid, err, mem_req;
  logic [31:0] rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;

  logic        req1;
  logic [31:0] addr1;
  logic        gnt1, rvalid1, err1, mem_req1;
  logic [31:0] rdata1;
  logic [9:0]  mem_addr1;
  logic [31:0] mem_rdata1;

  logic [31:0] mem [0:1023];

  ibex_instr_responder u_dut (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_gnt_o(gnt), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  ibex_instr_responder #(.NUM_REQS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req1), .instr_gnt_o(gnt1), .instr_addr_i(addr1),
    .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1), .instr_err_o(err1),
    .mem_req_o(mem_req1), .mem_addr_o(mem_addr1), .mem_rdata_i(mem_rdata1)
  );

  // Synchronous-read SRAM models, one per instance.
  always @(posedge clk) begin
    if (mem_req)  mem_rdata  <= mem[mem_addr];
    if (mem_req1) mem_rdata1 <= mem[mem_addr1];
  end

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        h1, h2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expected response per rvalid; idle cycles must present zeros.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid cycle=%0d got=1 expected=0", cyc);
      end else begin
        e = sb.pop_front();
        check("rv_cycle", 32'(cyc), 32'(e.cyc));
        check("rdata", rdata, e.data);
        check("err", 32'(err), 32'(e.err));
      end
    end else begin
      check("idle_rvalid", 32'(rvalid), 32'h0);
      check("idle_rdata", rdata, 32'h0);
      check("idle_err", 32'(err), 32'h0);
    end
  end

  // One clock of stimulus: r/a to the default instance, r1/eg1 to the NUM_REQS=1 instance.
  task automatic step(input logic r, input logic [31:0] a, input logic rs,
                      input logic r1, input logic eg1);
    logic eg;
    logic inr;
    exp_t e;
    rst  = rs;
    req  = r;
    addr = a;
    req1 = r1;
    if (rs) sb.delete();
    @(negedge clk);
    eg  = r & ~rs;
    inr = (a < 32'h0000_1000);
    check("gnt", 32'(gnt), 32'(eg));
    check("mem_req", 32'(mem_req), 32'(eg & inr));
    check("mem_addr", 32'(mem_addr), (eg & inr) ? {22'h0, a[11:2]} : 32'h0);
    if (eg) begin
      e.cyc  = cyc + 2;
      e.err  = ~inr;
      e.data = inr ? mem[a[11:2]] : 32'h0;
      sb.push_back(e);
    end
    check("d1_gnt", 32'(gnt1), 32'(eg1));
    check("d1_rvalid", 32'(rvalid1), 32'(h2 & ~rs));
    check("d1_err", 32'(err1), 32'h0);
    if (rs) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = eg1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    mem[4] = 32'hDEAD_BEEF;
    h1    = 1'b0;
    h2    = 1'b0;
    rst   = 1'b1;
    req   = 1'b0;
    addr  = 32'h0;
    req1  = 1'b0;
    addr1 = 32'h0000_0008;

    // Reset with requests pending: nothing granted, all outputs quiet.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Single fetch of word 4.
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Streaming six consecutive words.
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Out-of-range boundary interleaved with in-range fetches.
    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Reset mid-flight discards both in-flight responses.
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 32'h28, 1'b0, 1'b0, 1'b0);
    idle(3);

    // NUM_REQS=1 with request held: grant on alternate cycles.
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, ((i % 2) == 0));
    idle(4);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
